// File: rtl/addsub_sequencer_if.sv
// rtl/addsub_sequencer_if.sv - start/ready/done handshake and operand/result bundle for addsub_sequencer
interface addsub_sequencer_if #(
  parameter int NIBBLES = 4
);
  localparam int WIDTH = 4 * NIBBLES;

  logic             start;
  logic             sel;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             ready;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             co;
  logic             ovf;
  logic             zero;

  // Requesting side: control logic issuing operations
  modport master (
    output start, sel, a, b,
    input  ready, busy, done, result, co, ovf, zero
  );

  // Sequencer side
  modport slave (
    input  start, sel, a, b,
    output ready, busy, done, result, co, ovf, zero
  );
endinterface

// File: rtl/addsub_sequencer.sv
// rtl/addsub_sequencer.sv - multi-nibble add/subtract sequencer over a single 4-bit step
module addsub_sequencer #(
  parameter int NIBBLES = 4
) (
  input  logic               clk,
  input  logic               rst,
  addsub_sequencer_if.slave  bus
);
  localparam int WIDTH = 4 * NIBBLES;
  localparam int IDXW  = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t            state_q;
  logic [IDXW-1:0]   idx_q;
  logic              carry_q;
  logic              msb_cin_q;
  logic              sel_q;
  logic [WIDTH-1:0]  a_q;
  logic [WIDTH-1:0]  b_q;
  logic [WIDTH-1:0]  work_q;
  logic [WIDTH-1:0]  result_q;
  logic              co_q;
  logic              ovf_q;
  logic              zero_q;
  logic              done_q;

  logic [3:0]        a_nib;
  logic [3:0]        b_nib;
  logic [4:0]        step_sum;
  logic              step_msb_cin;
  logic              last_step;

  // One nibble step of the shared 4-bit adder; b is inverted for subtraction
  always_comb begin
    a_nib        = a_q[{idx_q, 2'b00} +: 4];
    b_nib        = b_q[{idx_q, 2'b00} +: 4] ^ {4{sel_q}};
    step_sum     = {1'b0, a_nib} + {1'b0, b_nib} + {4'b0000, carry_q};
    // Carry into bit 3 of this nibble recovered from the sum bit and its operands
    step_msb_cin = step_sum[3] ^ a_nib[3] ^ b_nib[3];
    last_step    = (idx_q == IDXW'(NIBBLES - 1));
  end

  // Control FSM, nibble datapath and registered result/flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      carry_q   <= 1'b0;
      msb_cin_q <= 1'b0;
      sel_q     <= 1'b0;
      a_q       <= '0;
      b_q       <= '0;
      work_q    <= '0;
      result_q  <= '0;
      co_q      <= 1'b0;
      ovf_q     <= 1'b0;
      zero_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            a_q     <= bus.a;
            b_q     <= bus.b;
            sel_q   <= bus.sel;
            idx_q   <= '0;
            carry_q <= bus.sel;
            state_q <= RUN;
          end
        end
        RUN: begin
          work_q[{idx_q, 2'b00} +: 4] <= step_sum[3:0];
          carry_q <= step_sum[4];
          idx_q   <= idx_q + 1'b1;
          if (last_step) begin
            msb_cin_q <= step_msb_cin;
            state_q   <= DONE;
          end
        end
        DONE: begin
          // Results publish only here, so RUN never exposes a partial sum
          result_q <= work_q;
          co_q     <= carry_q;
          ovf_q    <= carry_q ^ msb_cin_q;
          zero_q   <= (work_q == '0);
          done_q   <= 1'b1;
          state_q  <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.ready  = (state_q == IDLE);
  assign bus.busy   = (state_q == RUN);
  assign bus.done   = done_q;
  assign bus.result = result_q;
  assign bus.co     = co_q;
  assign bus.ovf    = ovf_q;
  assign bus.zero   = zero_q;
endmodule

// File: tb/tb_addsub_sequencer.sv
// tb/tb_addsub_sequencer.sv - scoreboard bench for addsub_sequencer with reference arithmetic model
module tb_addsub_sequencer;
  localparam int N = 4;
  localparam int W = 4 * N;

  typedef struct packed {
    logic [W-1:0] result;
    logic         co;
    logic         ovf;
    logic         zero;
  } resp_t;

  logic  clk;
  logic  rst;
  int    n_checks;
  int    n_fail;
  resp_t sb_q[$];
  resp_t held;
  logic  prev_done;

  addsub_sequencer_if #(.NIBBLES(N)) bus ();

  addsub_sequencer #(.NIBBLES(N)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference: plain integer arithmetic on the full-width operands
  function automatic resp_t model(input logic [W-1:0] av, input logic [W-1:0] bv, input logic s);
    resp_t r;
    int    sa, sbv, exact;
    logic [W:0] full;
    if (s) full = {1'b0, av} + {1'b0, ~bv} + 1;
    else   full = {1'b0, av} + {1'b0, bv};
    sa    = int'($signed(av));
    sbv   = int'($signed(bv));
    exact = s ? (sa - sbv) : (sa + sbv);
    r.result = full[W-1:0];
    r.co     = full[W];
    r.ovf    = (exact > (2 ** (W - 1)) - 1) || (exact < -(2 ** (W - 1)));
    r.zero   = (r.result == '0);
    return r;
  endfunction

  // Monitor: every done pulse pops one expectation; outputs must hold between pulses
  initial begin
    held      = '0;
    prev_done = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        held      = '0;
        prev_done = 1'b0;
      end else if (bus.done) begin
        check("done_single_pulse", {31'd0, prev_done}, 32'd0);
        if (sb_q.size() == 0) begin
          check("done_unexpected", 32'd1, 32'd0);
        end else begin
          resp_t e;
          e = sb_q.pop_front();
          check("result", {13'd0, bus.result, bus.co, bus.ovf, bus.zero}, {13'd0, e});
          held = e;
        end
        prev_done = 1'b1;
      end else begin
        check("outputs_hold", {13'd0, bus.result, bus.co, bus.ovf, bus.zero}, {13'd0, held});
        prev_done = 1'b0;
      end
    end
  end

  // Issue one operation from a negedge and wait for its done pulse
  task automatic run_op(input logic [W-1:0] av, input logic [W-1:0] bv, input logic s);
    int cycles;
    check("ready_before_start", {31'd0, bus.ready}, 32'd1);
    bus.a = av; bus.b = bv; bus.sel = s; bus.start = 1'b1;
    sb_q.push_back(model(av, bv, s));
    @(negedge clk);
    bus.start = 1'b0;
    check("busy_after_start", {30'd0, bus.busy, bus.ready}, 32'd2);
    cycles = 0;
    while (!bus.done && cycles < 20) begin
      @(negedge clk);
      cycles++;
    end
    check("latency", cycles, N + 1);
  endtask

  logic [W-1:0] ta [6] = '{16'h1234, 16'h0005, 16'h8000, 16'h7FFF, 16'hFFFF, 16'h8000};
  logic [W-1:0] tbv[6] = '{16'h0FFF, 16'h0007, 16'h8000, 16'h0001, 16'h0001, 16'h0001};
  logic         ts [6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};

  initial begin
    int cyc, pushes, last_done;
    n_checks = 0;
    n_fail   = 0;
    bus.start = 1'b0; bus.sel = 1'b0; bus.a = '0; bus.b = '0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("reset_ctrl", {29'd0, bus.ready, bus.busy, bus.done}, 32'd4);
    check("reset_outputs", {13'd0, bus.result, bus.co, bus.ovf, bus.zero}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Directed corner cases: add, borrow, zero, signed overflow, carry wrap
    for (int i = 0; i < 6; i++) run_op(ta[i], tbv[i], ts[i]);

    // Randomized operations with random idle gaps
    for (int i = 0; i < 20; i++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      run_op(W'($urandom), W'($urandom), 1'($urandom));
    end

    // start pulsed with new operands during RUN and DONE is ignored
    begin
      bus.a = 16'h1111; bus.b = 16'h2222; bus.sel = 1'b0; bus.start = 1'b1;
      sb_q.push_back(model(16'h1111, 16'h2222, 1'b0));
      cyc = 0;
      @(negedge clk);
      while (!bus.done && cyc < 20) begin
        check("ready_low_while_busy", {31'd0, bus.ready}, 32'd0);
        bus.a = W'($urandom); bus.b = W'($urandom); bus.sel = 1'($urandom); bus.start = 1'b1;
        @(negedge clk);
        cyc++;
      end
      bus.start = 1'b0;
      check("ignored_start_latency", cyc, N + 1);
    end

    // Reset in the second RUN cycle aborts the operation
    @(negedge clk);
    bus.a = 16'hABCD; bus.b = 16'h1357; bus.sel = 1'b0; bus.start = 1'b1;
    sb_q.push_back(model(16'hABCD, 16'h1357, 1'b0));
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("abort_ctrl", {29'd0, bus.ready, bus.busy, bus.done}, 32'd4);
    check("abort_outputs", {13'd0, bus.result, bus.co, bus.ovf, bus.zero}, 32'd0);
    void'(sb_q.pop_back());
    @(negedge clk);
    #2 rst = 1'b0;
    repeat (N + 3) @(negedge clk);
    run_op(16'h00FF, 16'h0101, 1'b1);

    // Back-to-back with start held high
    pushes = 0; last_done = -1; cyc = 0;
    while ((pushes < 5 || sb_q.size() > 0) && cyc < 100) begin
      if (bus.ready && pushes < 5) begin
        bus.a = W'($urandom); bus.b = W'($urandom); bus.sel = 1'($urandom); bus.start = 1'b1;
        sb_q.push_back(model(bus.a, bus.b, bus.sel));
        pushes++;
      end
      @(negedge clk);
      cyc++;
      if (bus.done) begin
        if (last_done >= 0) check("b2b_period", cyc - last_done, N + 2);
        last_done = cyc;
      end
    end
    bus.start = 1'b0;

    repeat (N + 4) @(negedge clk);
    check("scoreboard_drained", sb_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
